// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Header length, memory sizing and the boot FSM state type.
package imem_boot_ctrl_pkg;

   localparam int unsigned TEXT_MEM_SIZE  = 1024;
   localparam int unsigned BOOT_HDR_BYTES = 4;

   typedef enum logic [1:0] {
      BS_LEN,
      BS_DATA,
      BS_RUN
   } boot_state_t;

   function automatic boot_state_t boot_reset_state(input bit boot_on_reset);
      return boot_on_reset ? BS_LEN : BS_RUN;
   endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream input and instruction-memory write/address port of the boot loader.
// master is the controller side, slave is the stream source / memory side.
interface imem_boot_ctrl_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned WIDTH  = 32
) ();

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_we;
   logic [WIDTH-1:0]  imem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_addr, imem_we, imem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_addr, imem_we, imem_wdata
   );

endinterface

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words.
// word_valid/word are combinational with the byte that completes the word.
module imem_boot_ctrl_byte_packer
   import imem_boot_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        valid,
   input  logic [7:0]  data,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int unsigned LANE_W = $clog2(BOOT_HDR_BYTES);

   logic [LANE_W-1:0] lane_q;
   logic [31:0]       asm_q;
   logic              last_lane;

   assign last_lane  = (lane_q == LANE_W'(BOOT_HDR_BYTES - 1));
   assign word_valid = valid && last_lane;
   assign word       = {data, asm_q[23:0]};

   // lane_q is exactly two bits wide, so the increment wraps 3 -> 0 by itself
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
         asm_q  <= '0;
      end else if (clear) begin
         lane_q <= '0;
         asm_q  <= '0;
      end else if (valid) begin
         asm_q[{lane_q, 3'b000} +: 8] <= data;
         lane_q                       <= lane_q + 1'b1;
      end
   end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot-load controller: loads a length-prefixed word stream into instruction memory
// while holding the core, then hands the memory address port to the fetch stage.
module imem_boot_ctrl
   import imem_boot_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned MEM_WORDS     = TEXT_MEM_SIZE / 4,
   parameter bit          BOOT_ON_RESET = 1'b1,
   localparam int unsigned ADDR_W       = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   imem_boot_ctrl_if.master  bus,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              core_hold,
   output logic              load_err
);

   boot_state_t       state_q, state_d;
   logic [31:0]       len_q, len_d;
   logic [31:0]       word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              load_err_q, load_err_d;

   logic              rx_ready;
   logic              accept;
   logic              word_valid;
   logic [31:0]       word;

   assign rx_ready = (state_q != BS_RUN);
   assign accept   = bus.rx_valid && rx_ready;

   imem_boot_ctrl_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_q == BS_RUN),
      .valid      (accept),
      .data       (bus.rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      wptr_d     = wptr_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      load_err_d = load_err_q;
      unique case (state_q)
         BS_LEN: begin
            if (word_valid) begin
               len_d      = word;
               word_cnt_d = '0;
               wptr_d     = '0;
               state_d    = (word == '0) ? BS_RUN : BS_DATA;
               if (word > MEM_WORDS) load_err_d = 1'b1;
            end
         end
         BS_DATA: begin
            // Leave one cycle after the last word so its write strobe completes first.
            // word_cnt_q stops at len_q, so it can never wrap.
            if (word_cnt_q == len_q) begin
               state_d = BS_RUN;
            end else if (word_valid) begin
               if (word_cnt_q < MEM_WORDS) begin
                  we_d    = 1'b1;
                  waddr_d = wptr_q;
                  wdata_d = word;
               end
               word_cnt_d = word_cnt_q + 32'd1;
               wptr_d     = wptr_q + 1'b1;
            end
         end
         BS_RUN: begin
            if (load_req) begin
               state_d    = BS_LEN;
               load_err_d = 1'b0;
               word_cnt_d = '0;
               wptr_d     = '0;
               waddr_d    = '0;
            end
         end
         default: state_d = boot_reset_state(BOOT_ON_RESET);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= boot_reset_state(BOOT_ON_RESET);
         len_q      <= '0;
         word_cnt_q <= '0;
         wptr_q     <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         wptr_q     <= wptr_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.rx_ready   = rx_ready;
   assign bus.imem_addr  = (state_q == BS_RUN) ? fetch_addr : waddr_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_wdata = wdata_q;
   assign core_hold      = (state_q != BS_RUN);
   assign load_err       = load_err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: 32-word memory, boot on reset.
// Memory writes are logged at the falling edge and compared with hand-computed values.
module tb_imem_boot_ctrl;

   localparam int unsigned MW = 32;
   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst;
   logic          load_req;
   logic [AW-1:0] fetch_addr;
   logic          core_hold;
   logic          load_err;

   int unsigned n_vec;
   int unsigned n_err;

   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   imem_boot_ctrl_if #(.ADDR_W(AW), .WIDTH(32)) bus ();

   imem_boot_ctrl #(
      .WIDTH         (32),
      .MEM_WORDS     (MW),
      .BOOT_ON_RESET (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .load_req   (load_req),
      .fetch_addr (fetch_addr),
      .core_hold  (core_hold),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         log_addr.push_back(32'(bus.imem_addr));
         log_data.push_back(bus.imem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns #1 after the edge that accepted the byte.
   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gapped);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], gapped ? $urandom_range(0, 3) : 0);
      end
   endtask

   task automatic reload();
      @(negedge clk);
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b1;
      load_req      = 1'b0;
      fetch_addr    = '0;
      bus.rx_valid  = 1'b0;
      bus.rx_data   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_hold", 32'(core_hold), 32'd1);
      chk("rst_ready", 32'(bus.rx_ready), 32'd1);
      chk("rst_we", 32'(bus.imem_we), 32'd0);
      chk("rst_wdata", bus.imem_wdata, 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);

      // Basic load: two words
      clear_log();
      send_word(32'h0000_0002, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      chk("basic_we0", 32'(bus.imem_we), 32'd1);
      chk("basic_wd0", bus.imem_wdata, 32'h0000_0013);
      chk("basic_wa0", 32'(bus.imem_addr), 32'd0);
      send_word(32'h0010_0093, 1'b0);
      chk("basic_we1", 32'(bus.imem_we), 32'd1);
      chk("basic_hold_wr", 32'(core_hold), 32'd1);
      @(posedge clk);
      #1;
      chk("basic_hold_run", 32'(core_hold), 32'd0);
      chk("basic_we_off", 32'(bus.imem_we), 32'd0);
      chk("basic_nwr", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("basic_a1", log_addr[1], 32'd1);
         chk("basic_d1", log_data[1], 32'h0010_0093);
      end
      chk("basic_err", 32'(load_err), 32'd0);

      // Zero-length header
      reload();
      chk("zero_hold_req", 32'(core_hold), 32'd1);
      chk("zero_ready_req", 32'(bus.rx_ready), 32'd1);
      clear_log();
      send_word(32'h0000_0000, 1'b0);
      chk("zero_hold", 32'(core_hold), 32'd0);
      chk("zero_ready", 32'(bus.rx_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("zero_nwr", 32'(log_addr.size()), 32'd0);

      // Oversize: 33 words into a 32-word memory
      reload();
      clear_log();
      send_word(32'd33, 1'b0);
      chk("ovr_err", 32'(load_err), 32'd1);
      for (int i = 0; i < 33; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
      chk("ovr_nostrobe", 32'(bus.imem_we), 32'd0);
      chk("ovr_hold_last", 32'(core_hold), 32'd1);
      @(posedge clk);
      #1;
      chk("ovr_hold_run", 32'(core_hold), 32'd0);
      chk("ovr_nwr", 32'(log_addr.size()), 32'd32);
      if (log_addr.size() == 32) begin
         chk("ovr_d0", log_data[0], 32'hA000_0000);
         chk("ovr_a31", log_addr[31], 32'd31);
         chk("ovr_d31", log_data[31], 32'hA000_001F);
      end

      // Run mode address pass-through, then reload with a gapped word
      fetch_addr = 5'h10;
      #1;
      chk("run_addr10", 32'(bus.imem_addr), 32'h10);
      chk("run_ready", 32'(bus.rx_ready), 32'd0);
      fetch_addr = 5'h07;
      #1;
      chk("run_addr07", 32'(bus.imem_addr), 32'h07);
      chk("run_err_sticky", 32'(load_err), 32'd1);
      reload();
      chk("rld_hold", 32'(core_hold), 32'd1);
      chk("rld_err_clr", 32'(load_err), 32'd0);
      clear_log();
      send_word(32'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b1);
      chk("gap_we", 32'(bus.imem_we), 32'd1);
      chk("gap_wd", bus.imem_wdata, 32'hDEAD_BEEF);
      chk("gap_wa", 32'(bus.imem_addr), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("gap_nwr", 32'(log_addr.size()), 32'd1);

      // Reset during a write cycle kills the strobe at once
      reload();
      send_word(32'd2, 1'b0);
      send_word(32'h4433_2211, 1'b0);
      chk("wrst_we_pre", 32'(bus.imem_we), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("wrst_we", 32'(bus.imem_we), 32'd0);
      chk("wrst_wdata", bus.imem_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset after two bytes of the first data word, then a clean reload
      send_word(32'd2, 1'b0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_we", 32'(bus.imem_we), 32'd0);
      chk("mrst_hold", 32'(core_hold), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      send_word(32'd1, 1'b0);
      send_word(32'hDDCC_BBAA, 1'b0);
      @(posedge clk);
      #1;
      chk("mrst_hold_run", 32'(core_hold), 32'd0);
      chk("mrst_nwr", 32'(log_addr.size()), 32'd1);
      if (log_addr.size() == 1) begin
         chk("mrst_a0", log_addr[0], 32'd0);
         chk("mrst_d0", log_data[0], 32'hDDCC_BBAA);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
